// File: rtl/synth_voice_master.sv
// synth_voice_master: turns note-on/off events into KEY/FREQ register writes on an Avalon-MM slave.
// Latency: free-voice note-on 2 writes (ready again 4 cycles after accept); retrigger/steal 3 writes (5); note-off 1 write (3).
// Backpressure: EVT_READY low from accept until the last write completes; AVM_WAITREQUEST stretches the current write.
// Optional feature: define VOICE_STEAL_EN to steal a busy voice round-robin instead of dropping the event.
module synth_voice_master #(
  parameter int NUM_VOICES = 8,
  parameter int KEY_BASE   = 32,
  parameter int FREQ_BASE  = 40
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        EVT_VALID,
  output logic        EVT_READY,
  input  logic        EVT_ON,
  input  logic [6:0]  EVT_NOTE,
  output logic [5:0]  AVM_ADDR,
  output logic [3:0]  AVM_BYTE_EN,
  output logic        AVM_WRITE,
  output logic        AVM_CS,
  output logic [31:0] AVM_WRITEDATA,
  input  logic        AVM_WAITREQUEST,
  output logic [7:0]  VOICES_ACTIVE,
  output logic [7:0]  DROP_CNT
);

  localparam logic [5:0] KEY_BASE_A  = 6'(KEY_BASE);
  localparam logic [5:0] FREQ_BASE_A = 6'(FREQ_BASE);

  typedef enum logic [2:0] {IDLE, LOOKUP, WR_KOFF, WR_FREQ, WR_KEY} state_t;

  state_t      state_q;
  logic        rdy_q;
  logic        evt_on_q;
  logic [6:0]  evt_note_q;
  logic [2:0]  voice_q;
  logic [7:0]  active_q;
  logic [6:0]  note_q [8];
  logic [7:0]  drop_q;
  logic        wr_q;
  logic [5:0]  addr_q;
  logic [31:0] data_q;

  logic        match_hit, free_hit;
  logic [2:0]  match_idx, free_idx, sel_voice_d;
  logic [5:0]  kaddr_d, faddr_d;

`ifdef VOICE_STEAL_EN
  logic [2:0]  steal_ptr_q, steal_ptr_d;

  // Round-robin steal pointer wraps at the last implemented voice
  always_comb begin
    steal_ptr_d = (steal_ptr_q == 3'(NUM_VOICES - 1)) ? 3'd0 : steal_ptr_q + 3'd1;
  end
`endif

  // Voice search: lowest-index active voice holding the latched note, lowest-index free voice
  always_comb begin
    match_hit = 1'b0;
    match_idx = '0;
    free_hit  = 1'b0;
    free_idx  = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (active_q[i] && (note_q[i] == evt_note_q)) begin
        match_hit = 1'b1;
        match_idx = 3'(i);
      end
      if (!active_q[i]) begin
        free_hit = 1'b1;
        free_idx = 3'(i);
      end
    end
  end

  // Voice chosen in LOOKUP and the first write address for it
  always_comb begin
    if (match_hit) begin
      sel_voice_d = match_idx;
    end else if (free_hit) begin
      sel_voice_d = free_idx;
    end else begin
`ifdef VOICE_STEAL_EN
      sel_voice_d = steal_ptr_q;
`else
      sel_voice_d = free_idx;
`endif
    end
    kaddr_d = KEY_BASE_A + {3'b000, sel_voice_d};
    faddr_d = FREQ_BASE_A + {3'b000, sel_voice_d};
  end

  // Control FSM: event handshake, voice table update and registered Avalon write outputs
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= IDLE;
      rdy_q      <= 1'b0;
      evt_on_q   <= 1'b0;
      evt_note_q <= '0;
      voice_q    <= '0;
      active_q   <= '0;
      for (int i = 0; i < 8; i++) note_q[i] <= '0;
      drop_q     <= '0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
`ifdef VOICE_STEAL_EN
      steal_ptr_q <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (EVT_VALID && rdy_q) begin
            evt_on_q   <= EVT_ON;
            evt_note_q <= EVT_NOTE;
            rdy_q      <= 1'b0;
            state_q    <= LOOKUP;
          end else begin
            rdy_q <= 1'b1;
          end
        end

        LOOKUP: begin
          if (evt_on_q) begin
            if (match_hit) begin
              // Retrigger: key off first so the voice restarts cleanly
              voice_q               <= sel_voice_d;
              active_q[sel_voice_d] <= 1'b1;
              note_q[sel_voice_d]   <= evt_note_q;
              wr_q    <= 1'b1;
              addr_q  <= kaddr_d;
              data_q  <= '0;
              state_q <= WR_KOFF;
            end else if (free_hit) begin
              voice_q               <= sel_voice_d;
              active_q[sel_voice_d] <= 1'b1;
              note_q[sel_voice_d]   <= evt_note_q;
              wr_q    <= 1'b1;
              addr_q  <= faddr_d;
              data_q  <= {25'b0, evt_note_q};
              state_q <= WR_FREQ;
            end else begin
`ifdef VOICE_STEAL_EN
              voice_q               <= sel_voice_d;
              active_q[sel_voice_d] <= 1'b1;
              note_q[sel_voice_d]   <= evt_note_q;
              steal_ptr_q <= steal_ptr_d;
              wr_q    <= 1'b1;
              addr_q  <= kaddr_d;
              data_q  <= '0;
              state_q <= WR_KOFF;
`else
              if (drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
              rdy_q   <= 1'b1;
              state_q <= IDLE;
`endif
            end
          end else if (match_hit) begin
            voice_q               <= sel_voice_d;
            active_q[sel_voice_d] <= 1'b0;
            wr_q    <= 1'b1;
            addr_q  <= kaddr_d;
            data_q  <= '0;
            state_q <= WR_KEY;
          end else begin
            // Note-off for a note nobody plays: silently ignored
            rdy_q   <= 1'b1;
            state_q <= IDLE;
          end
        end

        WR_KOFF: begin
          if (!AVM_WAITREQUEST) begin
            addr_q  <= FREQ_BASE_A + {3'b000, voice_q};
            data_q  <= {25'b0, evt_note_q};
            state_q <= WR_FREQ;
          end
        end

        WR_FREQ: begin
          if (!AVM_WAITREQUEST) begin
            addr_q  <= KEY_BASE_A + {3'b000, voice_q};
            data_q  <= {31'b0, evt_on_q};
            state_q <= WR_KEY;
          end
        end

        WR_KEY: begin
          if (!AVM_WAITREQUEST) begin
            wr_q    <= 1'b0;
            rdy_q   <= 1'b1;
            state_q <= IDLE;
          end
        end

        default: begin
          wr_q    <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign EVT_READY     = rdy_q;
  assign AVM_WRITE     = wr_q;
  assign AVM_CS        = wr_q;
  assign AVM_BYTE_EN   = {4{wr_q}};
  assign AVM_ADDR      = addr_q;
  assign AVM_WRITEDATA = data_q;
  assign VOICES_ACTIVE = active_q;
  assign DROP_CNT      = drop_q;

endmodule

// File: doc/synth_voice_master.md
# synth_voice_master

Avalon-MM write-only initiator that turns note-on/note-off events into register writes on the synthesizer's control register file. Holds an 8-entry voice table, assigns notes to voices, and writes the per-voice FREQ (word 40+v) and KEY (word 32+v) registers. Sits between the note event source and the control register slave on the same clock domain.

## Interface
Parameters:
- NUM_VOICES, 8, voice count; legal values 1-8.
- KEY_BASE, 32, word address of KEY0.
- FREQ_BASE, 40, word address of FREQ0.

Ports:
- CLK  in  1  system clock.
- RESET_N  in  1  asynchronous, active-low reset.
- EVT_VALID  in  1  event present.
- EVT_READY  out  1  block can accept an event.
- EVT_ON  in  1  1 = note-on, 0 = note-off.
- EVT_NOTE  in  7  note number.
- AVM_ADDR  out  6  word address.
- AVM_BYTE_EN  out  4  always 4'hF while writing.
- AVM_WRITE  out  1  write request.
- AVM_CS  out  1  chip select; equals AVM_WRITE.
- AVM_WRITEDATA  out  32  write data.
- AVM_WAITREQUEST  in  1  stall; the current write holds while high.
- VOICES_ACTIVE  out  8  bit v = voice v holds a note; bits ≥ NUM_VOICES read 0.
- DROP_CNT  out  8  saturating count of dropped events.

## Operation
- One clock, CLK. Reset is asynchronous and active-low on RESET_N.
- Voice table per voice: active bit and 7-bit note.
- States: IDLE, LOOKUP, WR_KOFF, WR_FREQ, WR_KEY.
- IDLE: EVT_READY=1. On EVT_VALID&EVT_READY, latch EVT_ON/EVT_NOTE and go to LOOKUP.
- LOOKUP (EVT_READY=0, one cycle). Decision priority:
  - Note-on, note already active in voice v: retrigger v. Go to WR_KOFF.
  - Note-on, free voice exists: take the lowest-index free v. Go to WR_FREQ.
  - Note-on, all voices busy: steal behaviour, see Configuration.
  - Note-off, matching active voice v: clear active[v]. Go to WR_KEY with data 0.
  - Note-off, no match: go to IDLE, no write, DROP_CNT unchanged.
  - A claimed voice has its table entry written here: active=1, note=latched note.
- WR_KOFF: addr KEY_BASE+v, data 0.
- WR_FREQ: addr FREQ_BASE+v, data {25'b0, note}.
- WR_KEY: addr KEY_BASE+v, data {31'b0, on}.
- Each WR_* state asserts AVM_WRITE/AVM_CS with stable ADDR and DATA. It advances on the first cycle where AVM_WAITREQUEST=0.
- Sequence order: WR_KOFF → WR_FREQ → WR_KEY → IDLE.
- DROP_CNT saturates at 255.

## Timing
- Reset values:
  - EVT_READY=0 while RESET_N low, and 1 in the first cycle after release.
  - AVM_WRITE=0, AVM_CS=0, AVM_ADDR=0, AVM_WRITEDATA=0.
  - VOICES_ACTIVE=0, DROP_CNT=0. The state machine resets to IDLE.
- All outputs are registered.
- Latencies, with WAITREQUEST=0 and the event accepted at cycle 0:
  - Free-voice note-on: LOOKUP at 1, FREQ write at 2, KEY write at 3, EVT_READY high at 4.
  - Retrigger or steal: 3 writes at cycles 2-4, EVT_READY at 5.
  - Note-off: write at 2, EVT_READY at 3.
- Every WAITREQUEST high cycle extends the current write by one cycle.
- AVM_WRITE never deasserts while WAITREQUEST is high.
- A new event is never accepted before the last write of the previous sequence completes.
- RESET_N low mid-sequence:
  - AVM_WRITE drops immediately (asynchronously) and the table clears.
  - The in-flight write is abandoned, and any partially written voice is not rewritten.
- VOICES_ACTIVE updates at the end of LOOKUP, which can be before the corresponding writes complete.

## Configuration
- VOICE_STEAL_EN defined:
  - A note-on with all voices busy steals voice steal_ptr. steal_ptr is a 3-bit pointer, reset 0.
  - The sequence WR_KOFF/WR_FREQ/WR_KEY runs on that voice, and its table entry is replaced.
  - steal_ptr then increments, wrapping at NUM_VOICES-1 → 0.
- VOICE_STEAL_EN undefined:
  - The same event is dropped: DROP_CNT+1, no writes, return to IDLE.
  - No steal_ptr logic is present.

## Test plan
- Reset, then note-on 60 → writes (40, 0x3C), then (32, 1); VOICES_ACTIVE=0x01; EVT_READY back high 4 cycles after accept.
- Note-on 60, then note-on 64, then note-off 60 → note 64 goes to voice 1 via (41, 0x40), (33, 1); note-off writes (32, 0); VOICES_ACTIVE=0x02.
- Note-on 60 twice → second event writes (32, 0), (40, 0x3C), (32, 1); VOICES_ACTIVE=0x01.
- 9 note-ons, notes 50-58:
  - With VOICE_STEAL_EN: 9th writes (32, 0), (40, 0x3A), (32, 1).
  - Without VOICE_STEAL_EN: no writes, DROP_CNT=1.
- Hold AVM_WAITREQUEST high 5 cycles during the FREQ write → ADDR/DATA stable and AVM_WRITE held for 6 cycles; EVT_READY stays low throughout.
- Pull RESET_N low during the KEY write → AVM_WRITE low the same cycle; VOICES_ACTIVE=0; DROP_CNT=0.
